// File: rtl/pio_access_arbiter.sv
// ============================================================================
// Module      : pio_access_arbiter
// Description : Arbitrates NUM_REQ requesters onto one Avalon-MM PIO slave,
//               issuing single-cycle accesses and returning a one-cycle ack.
//               Define PIO_ARB_FIXED_PRIO_EN for fixed (lowest index) priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_access_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [2*NUM_REQ-1:0]    req_address,
    input  logic [32*NUM_REQ-1:0]   req_writedata,
    output logic [NUM_REQ-1:0]      ack,
    output logic [31:0]             rsp_readdata,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy,
    output logic [1:0]              m_address,
    output logic                    m_chipselect,
    output logic                    m_write_n,
    output logic [31:0]             m_writedata,
    input  logic [31:0]             m_readdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_REQ - 1);

    state_t                 r_state;
    logic [ID_W-1:0]        w_start;
    logic [2*NUM_REQ-1:0]   w_dbl;
    logic [NUM_REQ-1:0]     w_rot;
    int                     w_off;
    int                     w_sum;
    logic [ID_W-1:0]        w_winner;
    logic [1:0]             w_sel_addr;
    logic [31:0]            w_sel_data;
    logic                   w_sel_write;

`ifdef PIO_ARB_FIXED_PRIO_EN
    assign w_start = '0;
`else
    logic [ID_W-1:0]        r_ptr;
    assign w_start = r_ptr;
`endif

    // Rotate the request vector so the search always begins at bit 0.
    assign w_dbl = {req, req} >> w_start;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    always_comb begin
        w_off       = 0;
        w_sum       = 0;
        w_winner    = '0;
        w_sel_addr  = '0;
        w_sel_data  = '0;
        w_sel_write = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = j;
            end
        end
        w_sum = int'(w_start) + w_off;
        if (w_sum >= NUM_REQ) begin
            w_sum = w_sum - NUM_REQ;
        end
        w_winner = ID_W'(w_sum);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_sel_addr  = req_address[2*i +: 2];
                w_sel_data  = req_writedata[32*i +: 32];
                w_sel_write = req_write[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            ack          <= '0;
            rsp_readdata <= '0;
            grant_id     <= '0;
            busy         <= 1'b0;
            m_address    <= '0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= '0;
`ifndef PIO_ARB_FIXED_PRIO_EN
            r_ptr        <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    ack <= '0;
                    if (|req) begin
                        grant_id     <= w_winner;
                        m_address    <= w_sel_addr;
                        m_writedata  <= w_sel_data;
                        m_write_n    <= ~w_sel_write;
                        m_chipselect <= 1'b1;
                        busy         <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end else begin
                        m_chipselect <= 1'b0;
                        m_write_n    <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // Slave readdata is only valid while chipselect is high.
                    if (m_write_n) begin
                        rsp_readdata <= m_readdata;
                    end
                    m_chipselect <= 1'b0;
                    m_write_n    <= 1'b1;
                    ack          <= NUM_REQ'(1) << grant_id;
                    r_state      <= ST_ACK;
                end
                ST_ACK: begin
                    ack     <= '0;
                    busy    <= 1'b0;
`ifndef PIO_ARB_FIXED_PRIO_EN
                    r_ptr   <= (grant_id == c_last_id) ? '0 : grant_id + ID_W'(1);
`endif
                    r_state <= ST_IDLE;
                end
                default: begin
                    ack          <= '0;
                    busy         <= 1'b0;
                    m_chipselect <= 1'b0;
                    m_write_n    <= 1'b1;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
